neuron_mac: RTL and testbench
=============================

NEURON_MAC -- requirements
Module: neuron_mac

Interface
REQ-001 The block SHALL take parameter dataWidth, default 16, as the width of input samples and weights.
REQ-002 The block SHALL take parameter numWeight, default 4, as the number of inputs per neuron; legal range 2..64.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, the reset; synchronous and active-high.
REQ-005 The block SHALL have port myinput, input, dataWidth bits, a signed input sample.
REQ-006 The block SHALL have port myinputValid, input, 1 bit; myinput is accepted in every cycle where it is high.
REQ-007 The block SHALL have port weightValid, input, 1 bit, the weight write enable.
REQ-008 The block SHALL have port weightAddr, input, clog2(numWeight) bits, the weight write index.
REQ-009 The block SHALL have port weightIn, input, dataWidth bits, the signed weight write data.
REQ-010 The block SHALL have port biasValid, input, 1 bit, the bias write enable.
REQ-011 The block SHALL have port biasIn, input, 2*dataWidth bits, a signed bias already in product format.
REQ-012 The block SHALL have port sum, output, 2*dataWidth bits, the signed saturated neuron sum that feeds the activation stage.
REQ-013 The block SHALL have port outvalid, output, 1 bit, a one-cycle pulse that qualifies sum.

Function
REQ-014 Weight storage SHALL be a numWeight x dataWidth register array, written when weightValid is high.
REQ-015 The bias SHALL be held in a 2*dataWidth register, written when biasValid is high.
REQ-016 Weight read and write to the same index in the same cycle SHALL return the old weight to the datapath.
REQ-017 An input counter SHALL select the weight for each accepted sample, running 0..numWeight-1.
- It increments only on myinputValid.
- It wraps from numWeight-1 to 0.
REQ-018 Stage 1: on an accepted sample, a registered product SHALL capture signed(myinput) x signed(weight[cnt]).
- Product is 2*dataWidth bits.
- A first flag (cnt==0) and a last flag (cnt==numWeight-1) travel with it.
REQ-019 Stage 2: when the stage-1 valid is set, the accumulator SHALL load sat(base + product).
- base = bias when the first flag is set.
- base = the current accumulator otherwise.
REQ-020 sat() SHALL be a signed add with overflow clamping.
- Positive overflow clamps to 0x7FFF...F.
- Negative overflow clamps to 0x800...0.
- Clamping is applied per addition and is not sticky.
REQ-021 When the stage-2 update carries the last flag, sum SHALL load the new accumulator value and outvalid SHALL be high for exactly that cycle.
REQ-022 Latency SHALL be exactly 2 cycles: the last sample accepted at cycle T gives outvalid high at T+2.
REQ-023 sum SHALL hold its value between outvalid pulses.
REQ-024 Gaps in myinputValid SHALL stall nothing and SHALL NOT change the result.
- Pipeline valid bits track each sample.
- No bubbles are inserted for back-to-back vectors.
REQ-025 Weight or bias writes during a vector SHALL take effect for samples accepted after the write cycle.

Reset
REQ-026 While rst is high at a clock edge, the following SHALL clear to 0: counter, pipeline valids, product, accumulator, sum, outvalid, all weights and bias.
REQ-027 Reset mid-vector SHALL discard partial accumulation; the next accepted sample is index 0.
REQ-028 Writes and myinputValid SHALL be ignored in any cycle rst is high.

Verification
REQ-029 The bench SHALL cover the following basic case.
- Setup: weights 0x0001 x4, bias 0; inputs 1,2,3,4 back-to-back.
- Response: sum=0x0000000A and outvalid single pulse 2 cycles after input 4.
REQ-030 The bench SHALL cover the following negative-weight case.
- Setup: weights 0xFFFF x4, bias 0x00000005; inputs 1,2,3,4.
- Response: sum=0xFFFFFFFB.
REQ-031 The bench SHALL cover the following saturation cases.
- Weights 0x7FFF and inputs 0x7FFF x4, bias 0: sum=0x7FFFFFFF.
- Weights 0x8000 and inputs 0x7FFF x4, bias 0: sum=0x80000000.
REQ-032 The bench SHALL cover the following back-to-back case.
- Setup: 8 consecutive samples, weights 1, bias 0; inputs 1..4 then 5..8.
- Response: outvalid pulses 4 cycles apart with sums 10 then 26.
REQ-033 The bench SHALL cover the following gap case.
- Setup: inputs 1..4 with myinputValid low for 3 random cycles between samples.
- Response: sum=10 and outvalid 2 cycles after the last accepted sample.
REQ-034 The bench SHALL cover the following mid-vector reset case.
- Setup: reset after 2 samples, reload weights 1, then inputs 1..4.
- Response: only sum=10 appears, with no stale pulse.

Source files
------------

// File: rtl/neuron_mac.sv
// Multiply-accumulate core of one neuron: per-sample weight multiply, biased saturating
// accumulation over numWeight samples, and a registered sum qualified by outvalid.
module neuron_mac #(
  parameter int unsigned dataWidth = 16,
  parameter int unsigned numWeight = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [dataWidth-1:0]         myinput,
  input  logic                         myinputValid,
  input  logic                         weightValid,
  input  logic [$clog2(numWeight)-1:0] weightAddr,
  input  logic [dataWidth-1:0]         weightIn,
  input  logic                         biasValid,
  input  logic [2*dataWidth-1:0]       biasIn,
  output logic [2*dataWidth-1:0]       sum,
  output logic                         outvalid
);

  localparam int unsigned AddrW = $clog2(numWeight);
  localparam int unsigned ProdW = 2 * dataWidth;
  localparam logic [AddrW-1:0] LastIdx = AddrW'(numWeight - 1);
  localparam logic [ProdW-1:0] SatMax  = {1'b0, {(ProdW - 1){1'b1}}};
  localparam logic [ProdW-1:0] SatMin  = {1'b1, {(ProdW - 1){1'b0}}};

  logic [dataWidth-1:0] weight_q [numWeight];
  logic [dataWidth-1:0] weight_d [numWeight];
  logic [ProdW-1:0]     bias_q, bias_d;
  logic [AddrW-1:0]     cnt_q, cnt_d;
  logic                 p1_valid_q, p1_valid_d;
  logic                 first_q, first_d;
  logic                 last_q, last_d;
  logic [ProdW-1:0]     prod_q, prod_d;
  logic [ProdW-1:0]     acc_q, acc_d;
  logic [ProdW-1:0]     sum_q, sum_d;
  logic                 outvalid_q, outvalid_d;

  logic [ProdW-1:0]     in_ext, w_ext;
  logic [ProdW-1:0]     base;
  logic [ProdW:0]       add_ext;
  logic [ProdW-1:0]     acc_new;

  // Storage writes; the datapath reads the registered copy, so same-index writes see old data.
  always_comb begin
    bias_d = biasValid ? biasIn : bias_q;
    for (int i = 0; i < int'(numWeight); i++) begin
      weight_d[i] = weight_q[i];
      if (weightValid && (weightAddr == AddrW'(i))) begin
        weight_d[i] = weightIn;
      end
    end
  end

  // Stage 1: sign-extend both operands so the low ProdW bits hold the signed product.
  always_comb begin
    in_ext     = {{dataWidth{myinput[dataWidth-1]}}, myinput};
    w_ext      = {{dataWidth{weight_q[cnt_q][dataWidth-1]}}, weight_q[cnt_q]};
    cnt_d      = cnt_q;
    p1_valid_d = myinputValid;
    prod_d     = prod_q;
    first_d    = first_q;
    last_d     = last_q;
    if (myinputValid) begin
      cnt_d   = (cnt_q == LastIdx) ? '0 : cnt_q + AddrW'(1);
      prod_d  = in_ext * w_ext;
      first_d = (cnt_q == '0);
      last_d  = (cnt_q == LastIdx);
    end
  end

  // Stage 2: one guard bit detects overflow; clamping is per addition.
  always_comb begin
    base    = first_q ? bias_q : acc_q;
    add_ext = {base[ProdW-1], base} + {prod_q[ProdW-1], prod_q};
    if (add_ext[ProdW] != add_ext[ProdW-1]) begin
      acc_new = add_ext[ProdW] ? SatMin : SatMax;
    end else begin
      acc_new = add_ext[ProdW-1:0];
    end
    acc_d      = acc_q;
    sum_d      = sum_q;
    outvalid_d = 1'b0;
    if (p1_valid_q) begin
      acc_d = acc_new;
      if (last_q) begin
        sum_d      = acc_new;
        outvalid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(numWeight); i++) begin
        weight_q[i] <= '0;
      end
      bias_q     <= '0;
      cnt_q      <= '0;
      p1_valid_q <= 1'b0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
      prod_q     <= '0;
      acc_q      <= '0;
      sum_q      <= '0;
      outvalid_q <= 1'b0;
    end else begin
      weight_q   <= weight_d;
      bias_q     <= bias_d;
      cnt_q      <= cnt_d;
      p1_valid_q <= p1_valid_d;
      first_q    <= first_d;
      last_q     <= last_d;
      prod_q     <= prod_d;
      acc_q      <= acc_d;
      sum_q      <= sum_d;
      outvalid_q <= outvalid_d;
    end
  end

  assign sum      = sum_q;
  assign outvalid = outvalid_q;

endmodule

// File: tb/tb_neuron_mac.sv
// Scoreboard bench for neuron_mac: stimulus pushes expected sums and arrival cycles, a
// negedge monitor pops and compares on every outvalid and checks sum holds in between.
module tb_neuron_mac;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] myinput;
  logic        myinputValid;
  logic        weightValid;
  logic [1:0]  weightAddr;
  logic [15:0] weightIn;
  logic        biasValid;
  logic [31:0] biasIn;
  logic [31:0] sum;
  logic        outvalid;

  typedef struct {
    logic [31:0] sum;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  logic [31:0] hold_exp = '0;
  bit          chk_hold = 1'b0;

  neuron_mac #(
    .dataWidth(16),
    .numWeight(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .myinput     (myinput),
    .myinputValid(myinputValid),
    .weightValid (weightValid),
    .weightAddr  (weightAddr),
    .weightIn    (weightIn),
    .biasValid   (biasValid),
    .biasIn      (biasIn),
    .sum         (sum),
    .outvalid    (outvalid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Monitor: every pulse must match the head of the scoreboard, idle cycles must hold sum.
  always @(negedge clk) begin
    if (outvalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL stale_pulse: got sum %h with outvalid, expected no pulse", sum);
      end else begin
        mon_e = exp_q.pop_front();
        check("sum", sum, mon_e.sum);
        check("latency", 32'(cyc), 32'(mon_e.cyc));
        hold_exp = mon_e.sum;
      end
    end else if (chk_hold) begin
      check("hold", sum, hold_exp);
    end
  end

  // Writes and samples are driven during reset and must all be ignored.
  task automatic do_reset();
    chk_hold     = 1'b0;
    rst          = 1'b1;
    weightValid  = 1'b1;
    weightAddr   = 2'd0;
    weightIn     = 16'h0005;
    biasValid    = 1'b1;
    biasIn       = 32'h0000_0007;
    myinputValid = 1'b1;
    myinput      = 16'h0003;
    repeat (2) @(posedge clk);
    #1;
    rst          = 1'b0;
    weightValid  = 1'b0;
    biasValid    = 1'b0;
    myinputValid = 1'b0;
    hold_exp     = '0;
    chk_hold     = 1'b1;
    check("rst_sum", sum, 32'h0);
    check("rst_outvalid", 32'(outvalid), 32'h0);
  endtask

  task automatic load(input logic [15:0] w, input logic [31:0] b);
    for (int i = 0; i < 4; i++) begin
      weightValid = 1'b1;
      weightAddr  = 2'(i);
      weightIn    = w;
      biasValid   = (i == 0);
      biasIn      = b;
      @(posedge clk);
      #1;
    end
    weightValid = 1'b0;
    biasValid   = 1'b0;
  endtask

  task automatic sample(input logic [15:0] x, input bit last, input logic [31:0] exp);
    myinputValid = 1'b1;
    myinput      = x;
    if (last) exp_q.push_back('{sum: exp, cyc: cyc + 2});
    @(posedge clk);
    #1;
    myinputValid = 1'b0;
    myinput      = 16'hA5A5;
  endtask

  task automatic send_vec(input logic [15:0] x0, input logic [15:0] x1, input logic [15:0] x2,
                          input logic [15:0] x3, input logic [31:0] exp, input int gap);
    logic [15:0] xs [4];
    xs = '{x0, x1, x2, x3};
    for (int i = 0; i < 4; i++) begin
      sample(xs[i], i == 3, exp);
      if (i < 3) repeat (gap) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    rst          = 1'b1;
    myinput      = '0;
    myinputValid = 1'b0;
    weightValid  = 1'b0;
    weightAddr   = '0;
    weightIn     = '0;
    biasValid    = 1'b0;
    biasIn       = '0;
    do_reset();

    // Weights and bias still zero: writes during reset must not have landed.
    send_vec(16'd1, 16'd2, 16'd3, 16'd4, 32'h0000_0000, 0);

    load(16'h0001, 32'h0);
    send_vec(16'd1, 16'd2, 16'd3, 16'd4, 32'h0000_000A, 0);

    load(16'hFFFF, 32'h0000_0005);
    send_vec(16'd1, 16'd2, 16'd3, 16'd4, 32'hFFFF_FFFB, 0);

    load(16'h7FFF, 32'h0);
    send_vec(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 32'h7FFF_FFFF, 0);
    load(16'h8000, 32'h0);
    send_vec(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 32'h8000_0000, 0);

    // Back-to-back vectors, no bubble between them.
    load(16'h0001, 32'h0);
    send_vec(16'd1, 16'd2, 16'd3, 16'd4, 32'd10, 0);
    send_vec(16'd5, 16'd6, 16'd7, 16'd8, 32'd26, 0);

    send_vec(16'd1, 16'd2, 16'd3, 16'd4, 32'd10, 3);

    // Weight write on the same cycle its slot is read: old weight used, new one next vector.
    sample(16'd1, 1'b0, 32'h0);
    sample(16'd2, 1'b0, 32'h0);
    weightValid = 1'b1;
    weightAddr  = 2'd2;
    weightIn    = 16'd3;
    sample(16'd3, 1'b0, 32'h0);
    weightValid = 1'b0;
    sample(16'd4, 1'b1, 32'd10);
    send_vec(16'd1, 16'd2, 16'd3, 16'd4, 32'd16, 0);

    // Mid-vector reset drops the partial sum and restarts the index.
    load(16'h0001, 32'h0);
    sample(16'd1, 1'b0, 32'h0);
    sample(16'd2, 1'b0, 32'h0);
    do_reset();
    load(16'h0001, 32'h0);
    send_vec(16'd1, 16'd2, 16'd3, 16'd4, 32'd10, 0);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    check("drain", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
